// File: rtl/key_evt_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared types for the key event decoder:
//   key_evt_type_e : event type codes presented on evt_type (code 3 unused,
//                    REPEAT code stays reserved even when repeats are disabled)
//   key_state_e    : per-key classification state
//   key_evt_t      : one FIFO entry (key index + event type)
// -----------------------------------------------------------------------------
package key_evt_pkg;

  // Key index field width inside a FIFO entry; supports up to 256 keys.
  localparam int KEY_IDX_W = 8;

  typedef enum logic [1:0] {
    KEY_EVT_SHORT  = 2'd0,
    KEY_EVT_LONG   = 2'd1,
    KEY_EVT_REPEAT = 2'd2
  } key_evt_type_e;

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_PRESS = 2'd1,
    KS_HOLD  = 2'd2
  } key_state_e;

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    key_evt_type_e        typ;
  } key_evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// -----------------------------------------------------------------------------
// key_evt_fifo
// Generic synchronous FIFO with a look-ahead head output.
// Parameters:
//   DEPTH : number of entries, power of two, >= 2
//   T     : entry type
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push       : write push_data; accepted when not full, or when full and
//                a pop happens in the same cycle
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   full/empty : occupancy status
//   head       : current head entry, read straight from storage
// -----------------------------------------------------------------------------
module key_evt_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok;
  logic         pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage holds data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Classifies debounced key activity into SHORT / LONG / REPEAT events and
// queues them in a small FIFO with a valid/ready handshake.
//
// Optional feature macro: KEY_EVT_REPEAT_EN
//   defined   : REPEAT events every REPEAT_CNT high samples after LONG
//   undefined : HOLD only waits for release, REPEAT never emitted
//
// Parameters: NUM_KEYS, LONG_CNT (>=2), REPEAT_CNT (>=2), FIFO_DEPTH (power
//             of two, >=2), CNT_W (must hold LONG_CNT)
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   key_level  : debounced key levels, 1 = pressed
//   evt_valid  : FIFO not empty
//   evt_ready  : consumer takes the head entry when evt_valid && evt_ready
//   evt_key    : key index of the head entry (0 when empty)
//   evt_type   : 0 SHORT, 1 LONG, 2 REPEAT (0 when empty)
//   ovf_clr    : clears the overflow flag
//   overflow   : sticky, an event was lost
// -----------------------------------------------------------------------------
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS   = 3,
  parameter int LONG_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key_level,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic [1:0]                  evt_type,
  input  logic                        ovf_clr,
  output logic                        overflow
);

  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

  logic [NUM_KEYS-1:0] pend_vld_w;
  key_evt_type_e       pend_type_w [NUM_KEYS];
  logic [NUM_KEYS-1:0] drop_w;
  logic [NUM_KEYS-1:0] pend_clr;

  logic                 arb_vld;
  logic [KEY_IDX_W-1:0] arb_idx;
  key_evt_type_e        arb_type;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  key_evt_t             push_data;
  key_evt_t             head;

  logic                 overflow_q, overflow_d;

  // ---------------------------------------------------------------------------
  // Per-key classifier and 1-deep pending register
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_vld_q, pend_vld_d;
    key_evt_type_e       pend_type_q, pend_type_d;
    logic                emit;
    key_evt_type_e       emit_type;
    logic                drop;

    // cnt counts high samples already seen in PRESS, and samples since the
    // last LONG/REPEAT in HOLD.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      emit      = 1'b0;
      emit_type = KEY_EVT_SHORT;
      case (state_q)
        KS_IDLE: begin
          if (key_level[k]) begin
            state_d = KS_PRESS;
            cnt_d   = CNT_W'(1);
          end
        end
        KS_PRESS: begin
          if (!key_level[k]) begin
            emit      = 1'b1;
            emit_type = KEY_EVT_SHORT;
            state_d   = KS_IDLE;
            cnt_d     = '0;
          end else if (cnt_q == LONG_LAST) begin
            emit      = 1'b1;
            emit_type = KEY_EVT_LONG;
            state_d   = KS_HOLD;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        KS_HOLD: begin
          if (!key_level[k]) begin
            state_d = KS_IDLE;
            cnt_d   = '0;
          end
`ifdef KEY_EVT_REPEAT_EN
          else if (cnt_q == REP_LAST) begin
            emit      = 1'b1;
            emit_type = KEY_EVT_REPEAT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        default: begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A slot being pushed into the FIFO this edge counts as free, so a new
    // event on the same key can take it without loss.
    always_comb begin
      pend_vld_d  = pend_vld_q && !pend_clr[k];
      pend_type_d = pend_type_q;
      drop        = 1'b0;
      if (emit) begin
        if (pend_vld_d) begin
          drop = 1'b1;
        end else begin
          pend_vld_d  = 1'b1;
          pend_type_d = emit_type;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= KS_IDLE;
        cnt_q      <= '0;
        pend_vld_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        pend_vld_q <= pend_vld_d;
      end
    end

    always_ff @(posedge clk) begin
      pend_type_q <= pend_type_d;
    end

    assign pend_vld_w[k]  = pend_vld_q;
    assign pend_type_w[k] = pend_type_q;
    assign drop_w[k]      = drop;
  end

  // ---------------------------------------------------------------------------
  // Arbiter: lowest-index occupied pending goes to the FIFO, one per cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_vld  = 1'b0;
    arb_idx  = '0;
    arb_type = KEY_EVT_SHORT;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_vld_w[k]) begin
        arb_vld  = 1'b1;
        arb_idx  = KEY_IDX_W'(k);
        arb_type = pend_type_w[k];
      end
    end
  end

  assign pop  = !fifo_empty && evt_ready;
  // Pending entries wait, rather than drop, while the FIFO is full.
  assign push = arb_vld && (!fifo_full || pop);

  always_comb begin
    pend_clr = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      pend_clr[k] = push && (arb_idx == KEY_IDX_W'(k));
    end
  end

  assign push_data.key = arb_idx;
  assign push_data.typ = arb_type;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (key_evt_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Head fields are forced to zero when empty so that unwritten storage never
  // reaches the outputs.
  assign evt_valid = !fifo_empty;
  assign evt_key   = fifo_empty ? '0 : head.key[KEY_W-1:0];
  assign evt_type  = fifo_empty ? 2'd0 : head.typ;

  // ---------------------------------------------------------------------------
  // Sticky overflow: a drop in the same cycle as ovf_clr wins
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d = overflow_q;
    if (|drop_w)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule
